// File: rtl/updown_set_counter.sv
// ============================================================================
// Module      : updown_set_counter
// Description : Modulo up/down counter with parallel load and clear.
//               Optional macro UDS_SATURATE_EN switches boundary steps from
//               wrap-around to saturation (wrap still pulses on a blocked step).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_set_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);

  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("updown_set_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  // One extra bit keeps MODULUS-1 and count+1 exact when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH:0]   w_count_ext;
  logic [WIDTH:0]   w_set_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_count_ext = {1'b0, r_count};
  assign w_set_ext   = {1'b0, set_value};
  assign w_inc       = w_count_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec       = w_count_ext - {{WIDTH{1'b0}}, 1'b1};
  assign w_at_max    = (w_count_ext == c_max);
  assign w_at_zero   = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (set) begin
      r_count <= (w_set_ext > c_max) ? c_max[WIDTH-1:0] : set_value;
      r_wrap  <= 1'b0;
    end else if (up && !down) begin
      if (w_at_max) begin
`ifdef UDS_SATURATE_EN
        r_count <= r_count;
`else
        r_count <= '0;
`endif
        r_wrap  <= 1'b1;
      end else begin
        r_count <= w_inc[WIDTH-1:0];
        r_wrap  <= 1'b0;
      end
    end else if (down && !up) begin
      if (w_at_zero) begin
`ifdef UDS_SATURATE_EN
        r_count <= r_count;
`else
        r_count <= c_max[WIDTH-1:0];
`endif
        r_wrap  <= 1'b1;
      end else begin
        r_count <= w_dec[WIDTH-1:0];
        r_wrap  <= 1'b0;
      end
    end else begin
      r_count <= r_count;
      r_wrap  <= 1'b0;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign at_max  = w_at_max;
  assign at_zero = w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_updown_set_counter.sv
// ============================================================================
// Module      : tb_updown_set_counter
// Description : Directed self-checking bench for updown_set_counter across
//               several WIDTH/MODULUS configurations (honours UDS_SATURATE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_set_counter;

  logic clk = 1'b0;
  logic rst, clr, set, up, down;
  logic [7:0]  sv8;
  logic [11:0] sv12;
  logic [3:0]  sv4;

  logic [7:0]  cnt8, cnt200;
  logic [11:0] cnt12;
  logic [3:0]  cnt10;
  logic mx8, zr8, wr8, mx12, zr12, wr12, mx200, zr200, wr200, mx10, zr10, wr10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_set_counter #(.WIDTH(8), .MODULUS(256)) u8 (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .set_value(sv8), .up(up), .down(down),
    .count(cnt8), .at_max(mx8), .at_zero(zr8), .wrap(wr8));

  updown_set_counter #(.WIDTH(12), .MODULUS(4096)) u12 (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .set_value(sv12), .up(up), .down(down),
    .count(cnt12), .at_max(mx12), .at_zero(zr12), .wrap(wr12));

  updown_set_counter #(.WIDTH(8), .MODULUS(200)) u200 (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .set_value(sv8), .up(up), .down(down),
    .count(cnt200), .at_max(mx200), .at_zero(zr200), .wrap(wr200));

  updown_set_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .rst(rst), .clr(clr), .set(set), .set_value(sv4), .up(up), .down(down),
    .count(cnt10), .at_max(mx10), .at_zero(zr10), .wrap(wr10));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; set = 1'b0; up = 1'b1; down = 1'b0;
    sv8 = '0; sv12 = '0; sv4 = '0;
    #1;

    // Reset wins over up
    step();
    check("rst_count", 32'(cnt8), 0);
    check("rst_at_zero", 32'(zr8), 1);
    check("rst_at_max", 32'(mx8), 0);
    check("rst_wrap", 32'(wr8), 0);
    check("rst_count10", 32'(cnt10), 0);

    rst = 1'b0;
    repeat (5) step();
    check("count_to_5", 32'(cnt8), 5);
    clr = 1'b1; up = 1'b0;
    step();
    check("clr_count", 32'(cnt8), 0);

    // Load priority over up, full-range and over-range loads
    clr = 1'b0; set = 1'b1; up = 1'b1; sv12 = 12'd8;
    step();
    check("set_over_up", 32'(cnt12), 8);
    up = 1'b0; sv12 = 12'd4095;
    step();
    check("set_4095", 32'(cnt12), 4095);
    check("set_4095_at_max", 32'(mx12), 1);
    sv8 = 8'd250;
    step();
    check("set_overrange_200", 32'(cnt200), 199);
    check("set_overrange_at_max", 32'(mx200), 1);
    check("set_250_mod256", 32'(cnt8), 250);

    // Increment across the top boundary
    sv8 = 8'd254;
    step();
    check("set_254", 32'(cnt8), 254);
    set = 1'b0; up = 1'b1;
    step();
    check("inc1_count", 32'(cnt8), 255);
    check("inc1_wrap", 32'(wr8), 0);
    check("inc1_at_max", 32'(mx8), 1);
    step();
`ifdef UDS_SATURATE_EN
    check("inc2_count", 32'(cnt8), 255);
`else
    check("inc2_count", 32'(cnt8), 0);
    check("inc2_at_zero", 32'(zr8), 1);
`endif
    check("inc2_wrap", 32'(wr8), 1);
    step();
`ifdef UDS_SATURATE_EN
    check("inc3_count", 32'(cnt8), 255);
    check("inc3_wrap", 32'(wr8), 1);
`else
    check("inc3_count", 32'(cnt8), 1);
    check("inc3_wrap", 32'(wr8), 0);
`endif

    // Decrement across the bottom boundary, MODULUS=10
    up = 1'b0; set = 1'b1; sv4 = 4'd1;
    step();
    check("set_1_mod10", 32'(cnt10), 1);
    set = 1'b0; down = 1'b1;
    step();
    check("dec1_count", 32'(cnt10), 0);
    check("dec1_wrap", 32'(wr10), 0);
    check("dec1_at_zero", 32'(zr10), 1);
    step();
`ifdef UDS_SATURATE_EN
    check("dec2_count", 32'(cnt10), 0);
`else
    check("dec2_count", 32'(cnt10), 9);
    check("dec2_at_max", 32'(mx10), 1);
`endif
    check("dec2_wrap", 32'(wr10), 1);
    step();
`ifdef UDS_SATURATE_EN
    check("dec3_count", 32'(cnt10), 0);
    check("dec3_wrap", 32'(wr10), 1);
`else
    check("dec3_count", 32'(cnt10), 8);
    check("dec3_wrap", 32'(wr10), 0);
`endif
    up = 1'b1;
    step();
`ifdef UDS_SATURATE_EN
    check("updown_hold", 32'(cnt10), 0);
`else
    check("updown_hold", 32'(cnt10), 8);
`endif
    check("updown_wrap", 32'(wr10), 0);

    // Delay-counter usage: up only, from a clear
    up = 1'b0; down = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; up = 1'b1;
    repeat (15) step();
    check("delay_15", 32'(cnt8), 15);
    check("delay_15_mod10", 32'(cnt10), 5);
    clr = 1'b1; up = 1'b0;
    step();
    check("delay_clr", 32'(cnt8), 0);

    // Down from zero on the 256 counter
    clr = 1'b0; down = 1'b1;
    step();
`ifdef UDS_SATURATE_EN
    check("down_from_0", 32'(cnt8), 0);
`else
    check("down_from_0", 32'(cnt8), 255);
`endif
    check("down_from_0_wrap", 32'(wr8), 1);

    // Clear beats set
    down = 1'b0; clr = 1'b1; set = 1'b1; sv8 = 8'd7;
    step();
    check("clr_over_set", 32'(cnt8), 0);
    check("clr_over_set_wrap", 32'(wr8), 0);

    // Reset mid-sequence beats everything
    clr = 1'b0; sv8 = 8'd100;
    step();
    check("set_100", 32'(cnt8), 100);
    rst = 1'b1; set = 1'b1; up = 1'b1;
    step();
    check("rst_mid", 32'(cnt8), 0);
    check("rst_mid_12", 32'(cnt12), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_set_counter.md
# updown_set_counter

Synchronous modulo counter with increment, decrement, parallel load and clear. It is the shared counting primitive of the UART-to-NAND datapath: the 12-bit RAM address counter, the 8-bit command-position counter, and, with `down`/`set` tied low, the 8-bit delay counter. All state changes occur on the rising clock edge. `count` is a plain register output.

## Interface
Parameters:
- `WIDTH`, default 8: counter and load-value width in bits.
- `MODULUS`, default 256: count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; any other value is an elaboration error.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high; clock `clk`.
- `clr`  in  1: synchronous clear to 0.
- `set`  in  1: parallel load of `set_value`.
- `set_value`  in  WIDTH: value loaded when `set` wins priority.
- `up`  in  1: increment request.
- `down`  in  1: decrement request.
- `count`  out  WIDTH: current count, registered.
- `at_max`  out  1: combinational, high when `count == MODULUS-1`.
- `at_zero`  out  1: combinational, high when `count == 0`.
- `wrap`  out  1: registered one-cycle pulse, high in the cycle after a boundary crossing (a wrap, or a blocked step when saturating).

## Operation
Per rising edge, the first matching rule applies:
1. `rst`=1: `count`←0, `wrap`←0.
2. `clr`=1: `count`←0, `wrap`←0.
3. `set`=1: `count`←`set_value` if `set_value` < MODULUS, otherwise `count`←MODULUS-1. `wrap`←0.
4. `up`=1 and `down`=0: `count`←`count`+1. At MODULUS-1 the count goes to 0 (see Configuration) and `wrap`←1.
5. `down`=1 and `up`=0: `count`←`count`-1. At 0 the count goes to MODULUS-1 (see Configuration) and `wrap`←1.
6. Otherwise, including `up`=`down`=1: `count` holds and `wrap`←0.

Additional rules:
- Arithmetic is performed at WIDTH+1 bits internally, so no intermediate overflow occurs when MODULUS=2^WIDTH.
- `count` never holds a value ≥ MODULUS.
- `wrap` deasserts in any cycle not covered by rules 4 or 5 at a boundary.
- No power-on `initial` value is relied on. `count` is undefined until the first `rst`, `clr` or `set`.

## Timing
- Update latency is 1 cycle: inputs sampled at edge N appear on `count` after edge N.
- `at_max`/`at_zero` follow `count` combinationally, with no added latency.
- `wrap` is aligned with the `count` update that crossed the boundary.
- Reset values: `count`=0, `wrap`=0, `at_zero`=1, `at_max`=0 (for MODULUS>1).
- Simultaneous inputs resolve strictly by the priority list. Examples: `set` together with `up` performs a load only; `clr` together with `set` clears.
- Reset asserted mid-sequence takes effect at the next edge, regardless of other inputs.
- No handshake: every enable is level-sensitive and acts on every edge it is high. Holding `up` for k cycles advances the count by k mod MODULUS.

## Configuration
- Macro `UDS_SATURATE_EN`.
- Defined: step 4 at MODULUS-1 holds at MODULUS-1, and step 5 at 0 holds at 0. `wrap` still pulses for one cycle to flag the blocked step.
- Undefined (default): modulo wrap-around as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset/clear: drive `rst`=1 for 1 edge with `up`=1 → `count`=0, `at_zero`=1, `wrap`=0. Count to 5, then `clr`=1 for 1 edge → `count`=0.
- Load and priority (WIDTH=12, MODULUS=4096): `set`=1, `set_value`=8, `up`=1 → `count`=8. `set_value`=4095 → 4095, `at_max`=1. Check over-range load at WIDTH=8, MODULUS=200: `set_value`=250 → `count`=199.
- Increment wrap, default build, WIDTH=8: from 254 apply `up` for 3 edges → 255, 0, 1. `wrap` is high only in the cycle `count`=0.
- Decrement wrap with MODULUS=10: from 1 apply `down` for 3 edges → 0, 9, 8. `wrap` is high only in the cycle `count`=9. With `up`=`down`=1 the count holds at 8.
- Delay-counter usage: `down`=`set`=0, `up`=1 for 15 edges from a clear → `count`=15. Assert `clr` on the next edge → `count`=0.
- Build with `UDS_SATURATE_EN`: from 254 apply `up` for 3 edges → 255, 255, 255, with `wrap` high after edges 2 and 3. From 0 apply `down` → `count` stays 0 and `wrap`=1.
